// File: rtl/display_pkg.sv
// Shared definitions for the scanning display: word/digit geometry and
// the state encodings used by the display ownership arbiter.
package display_pkg;

    localparam int DISP_DATA_W = 32;
    localparam int DISP_DIGITS = 8;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_HOLD       = 2'd1;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        HOLD       = ST_HOLD,
        WAIT_FRAME = ST_WAIT_FRAME
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational rotating-priority picker: returns the first set request
// found when searching upward from (base+1) mod N, wrapping through base.
module rr_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] base,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int IDX_W = $clog2(N);

    int               c;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cand  = '0;
        // Walk from the lowest priority (base itself) up to base+1 so the
        // last hit, i.e. the highest priority one, is what remains.
        for (int off = N; off >= 1; off--) begin
            c    = (int'(base) + off) % N;
            cand = IDX_W'(c);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin owner of the shared 8-digit display; owners keep the screen
// for at least HOLD_CYCLES and only change hands on a scan-frame boundary.
module display_share_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DISP_DATA_W,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  data_in,
    input  logic                       frame_done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] disp_owner,
    output logic [DATA_W-1:0]          disp_data,
    output logic                       disp_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    arb_state_t       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [DATA_W-1:0] words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = data_in[i*DATA_W +: DATA_W];
        end
    end

    // From idle the rotation continues after whoever last held the screen.
    assign base = (state == IDLE) ? last_owner : disp_owner;

    rr_select #(
        .N (NUM_REQ)
    ) u_rr_select (
        .req   (req),
        .base  (base),
        .idx   (pick),
        .found (found)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            disp_owner <= '0;
            hold_cnt   <= '0;
            last_owner <= LAST_IDX;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt        <= ONE_HOT0 << pick;
                        disp_owner <= pick;
                        disp_valid <= 1'b1;
                        disp_data  <= words[pick];
                        hold_cnt   <= RELOAD;
                        state      <= HOLD;
                    end
                end

                HOLD: begin
                    disp_data <= words[disp_owner];
                    if (hold_cnt == '0) begin
                        state <= WAIT_FRAME;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                WAIT_FRAME: begin
                    if (!frame_done) begin
                        disp_data <= words[disp_owner];
                    end else if (found) begin
                        // Covers both a hand-over and the owner re-granting itself.
                        gnt        <= ONE_HOT0 << pick;
                        disp_owner <= pick;
                        disp_data  <= words[pick];
                        hold_cnt   <= RELOAD;
                        state      <= HOLD;
                    end else begin
                        gnt        <= '0;
                        disp_valid <= 1'b0;
                        last_owner <= disp_owner;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
